// File: rtl/axi_hdr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : axi_hdr_pkg                                                      |
// | Purpose : Shared types and helpers for the axi_stream header scheduler.    |
// |           State encoding, default widths, keep legality and popcount.      |
// | Ports   : n/a (package)                                                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package axi_hdr_pkg;

  localparam int DATA_WD_DEF      = 32;
  localparam int DATA_BYTE_WD_DEF = DATA_WD_DEF / 8;

  // Helpers operate on a fixed wide vector; callers zero-extend their keep.
  localparam int KEEP_MAX_WD = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    PKT   = 2'd2,
    DROP  = 2'd3
  } state_t;

  // Legal keep is nonzero and a right-aligned run of ones (2^n - 1).
  // keep & (keep+1) clears the lowest run of ones; anything left means a gap.
  function automatic logic keep_legal(input logic [KEEP_MAX_WD-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_MAX_WD'(1))) == '0);
  endfunction

  function automatic logic [7:0] popcount(input logic [KEEP_MAX_WD-1:0] keep);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX_WD; i++) begin
      n = n + {7'd0, keep[i]};
    end
    return n;
  endfunction

endpackage : axi_hdr_pkg
`default_nettype wire

// File: rtl/hdr_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hdr_rr_arbiter                                                   |
// | Purpose : Combinational round-robin pick: first set request at or after    |
// |           the pointer, wrapping N_REQ-1 -> 0.                              |
// | Ports   : i_req   [N_REQ]  request vector                                  |
// |           i_ptr   [ID_WD]  highest-priority requester index                |
// |           o_grant [N_REQ]  one-hot grant (zero when no request)            |
// |           o_id    [ID_WD]  encoded grant index                             |
// |           o_any            at least one request present                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hdr_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_WD = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_WD-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_WD-1:0] o_id,
  output logic             o_any
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = (int'(i_ptr) + i) % N_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = ID_WD'(w_idx);
      end
    end
  end

  assign o_any = |i_req;

endmodule : hdr_rr_arbiter
`default_nettype wire

// File: rtl/axi_stream_header_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_stream_header_sched                                          |
// | Purpose : Round-robin scheduler feeding one header per packet to the       |
// |           axi_stream header inserter. Snoops the inserter output and only  |
// |           offers the next header after the current packet's last beat.     |
// |           Headers with an illegal keep are dropped with a keep_err pulse.  |
// | Config  : HDR_SCHED_STATS_EN - builds the 32-bit completed-packet counter  |
// |           on pkt_cnt; otherwise pkt_cnt is tied to zero.                   |
// | Ports   : clk, rst_n (async active-low)                                    |
// |           req_valid/req_data/req_keep in, req_ready out  (requester side)  |
// |           valid_insert/data_insert/keep_insert/byte_insert_cnt out,        |
// |           ready_insert in                               (inserter header)  |
// |           valid_out/ready_out/last_out in               (output snoop)     |
// |           grant_id, busy, keep_err, pkt_cnt out         (status)           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module axi_stream_header_sched
  import axi_hdr_pkg::*;
#(
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int N_REQ        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WD-1:0]      req_data,
  input  logic [N_REQ*DATA_BYTE_WD-1:0] req_keep,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          valid_insert,
  output logic [DATA_WD-1:0]            data_insert,
  output logic [DATA_BYTE_WD-1:0]       keep_insert,
  output logic [BYTE_CNT_WD:0]          byte_insert_cnt,
  input  logic                          ready_insert,
  input  logic                          valid_out,
  input  logic                          ready_out,
  input  logic                          last_out,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy,
  output logic                          keep_err,
  output logic [31:0]                   pkt_cnt
);

  localparam int ID_WD = $clog2(N_REQ);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ID_WD-1:0]        r_ptr;
  logic [ID_WD-1:0]        r_grant_id;
  logic [N_REQ-1:0]        r_grant_oh;
  logic [DATA_WD-1:0]      r_data;
  logic [DATA_BYTE_WD-1:0] r_keep;
  logic [BYTE_CNT_WD:0]    r_cnt;

  logic [N_REQ-1:0]        w_arb_grant;
  logic [ID_WD-1:0]        w_arb_id;
  logic                    w_arb_any;
  logic [DATA_WD-1:0]      w_sel_data;
  logic [DATA_BYTE_WD-1:0] w_sel_keep;
  logic                    w_sel_legal;
  logic                    w_load;
  logic                    w_adv_ptr;
  logic [ID_WD-1:0]        w_ptr_nxt;
  logic                    w_pkt_done;
  logic                    w_valid_insert;
  logic [N_REQ-1:0]        w_req_ready;
  logic                    w_keep_err;

  hdr_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_WD (ID_WD)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_id    (w_arb_id),
    .o_any   (w_arb_any)
  );

  assign w_sel_data  = req_data[int'(w_arb_id)*DATA_WD +: DATA_WD];
  assign w_sel_keep  = req_keep[int'(w_arb_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign w_sel_legal = keep_legal(KEEP_MAX_WD'(w_sel_keep));

  // Pointer moves to the slot after whoever just finished (offered or dropped).
  assign w_ptr_nxt  = (r_grant_id == ID_WD'(N_REQ - 1)) ? '0 : r_grant_id + ID_WD'(1);

  // Output snoop only matters while a packet is in flight.
  assign w_pkt_done = (r_state == PKT) && valid_out && ready_out && last_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_adv_ptr      = 1'b0;
    w_valid_insert = 1'b0;
    w_req_ready    = '0;
    w_keep_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_load      = 1'b1;
          w_state_nxt = w_sel_legal ? OFFER : DROP;
        end
      end
      OFFER: begin
        w_valid_insert = 1'b1;
        if (ready_insert) begin
          w_req_ready = r_grant_oh;
          w_adv_ptr   = 1'b1;
          w_state_nxt = PKT;
        end
      end
      PKT: begin
        if (w_pkt_done) begin
          w_state_nxt = IDLE;
        end
      end
      DROP: begin
        w_req_ready = r_grant_oh;
        w_keep_err  = 1'b1;
        w_adv_ptr   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Header is captured once in IDLE and held until the requester is released,
  // so requester-side changes during OFFER never disturb the offered header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_grant_oh <= '0;
      r_data     <= '0;
      r_keep     <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_load) begin
        r_grant_id <= w_arb_id;
        r_grant_oh <= w_arb_grant;
        r_data     <= w_sel_data;
        r_keep     <= w_sel_keep;
        r_cnt      <= (BYTE_CNT_WD+1)'(popcount(KEEP_MAX_WD'(w_sel_keep)));
      end
      if (w_adv_ptr) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

`ifdef HDR_SCHED_STATS_EN
  logic [31:0] r_pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_pkt_done) begin
      r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`else
  assign pkt_cnt = '0;
`endif

  assign valid_insert    = w_valid_insert;
  assign data_insert     = r_data;
  assign keep_insert     = r_keep;
  assign byte_insert_cnt = r_cnt;
  assign req_ready       = w_req_ready;
  assign grant_id        = r_grant_id;
  assign busy            = (r_state != IDLE);
  assign keep_err        = w_keep_err;

endmodule : axi_stream_header_sched
`default_nettype wire
